adpll_ctrl: RTL and testbench

ADPLL_CTRL -- requirements
Module: adpll_ctrl

---
 rtl/adpll_pkg.sv | 37 +++
 rtl/adpll_ctrl_if.sv | 24 ++
 rtl/flag_sync.sv | 31 +++
 rtl/adpll_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_adpll_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adpll_pkg.sv
// adpll_pkg: shared types and default constants for the ADPLL controller.
//   state_e  - controller states (IDLE, SEARCH, TRACK, LOCKED)
//   dir_e    - classified phase-detector decision (NONE, UP, DN)
//   DEF_*    - default parameter values used by adpll_ctrl
//   classify - maps synchronized up/down flags onto a decision
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  localparam int DEF_CODE_W     = 7;
  localparam int DEF_SETTLE     = 4;
  localparam int DEF_LOCK_CNT   = 8;
  localparam int DEF_UNLOCK_CNT = 4;

  // Both flags high (or both low) is ambiguous and treated as no decision.
  function automatic dir_e classify(input logic up, input logic dn);
    if (up && !dn) begin
      return DIR_UP;
    end else if (!up && dn) begin
      return DIR_DN;
    end else begin
      return DIR_NONE;
    end
  endfunction

endpackage

// File: rtl/adpll_ctrl_if.sv
// adpll_ctrl_if: bundles the loop-control signals of adpll_ctrl.
//   en, flag_u, flag_d       - driven by the master (loop supervisor / PFD side)
//   dco_code, search_done,
//   lock                     - driven by the slave (the controller)
interface adpll_ctrl_if #(
  parameter int CODE_W = 7
);
  logic              en;
  logic              flag_u;
  logic              flag_d;
  logic [CODE_W-1:0] dco_code;
  logic              search_done;
  logic              lock;

  modport master (
    output en, flag_u, flag_d,
    input  dco_code, search_done, lock
  );

  modport slave (
    input  en, flag_u, flag_d,
    output dco_code, search_done, lock
  );
endinterface

// File: rtl/flag_sync.sv
// flag_sync: two-flop synchronizer for an asynchronous PFD flag.
//   clk   - destination clock
//   rst_b - synchronous active-low reset, clears both stages
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module flag_sync (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/adpll_ctrl.sv
// adpll_ctrl: digital loop controller for an all-digital PLL.
// A binary search finds the DCO code coarsely, then the loop tracks with
// +/-1 steps and declares lock after enough consecutive direction reversals.
//   IN_clk      - reference clock (only clock)
//   RESET_b     - synchronous active-low reset
//   EN          - loop enable; low forces IDLE
//   flagU/flagD - asynchronous PFD flags (raise / lower frequency)
//   DCO_code    - DCO control word, higher code = higher frequency
//   search_done - binary search finished
//   lock        - loop locked
module adpll_ctrl
  import adpll_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic              IN_clk,
  input  logic              RESET_b,
  input  logic              EN,
  input  logic              flagU,
  input  logic              flagD,
  output logic [CODE_W-1:0] DCO_code,
  output logic              search_done,
  output logic              lock
);

  localparam int STEP_W = CODE_W - 1;
  localparam int SET_W  = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int REV_W  = $clog2(LOCK_CNT + 1);
  localparam int RUN_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [STEP_W-1:0] STEP_INIT = {1'b1, {(STEP_W-1){1'b0}}};
  localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE - 1);

  function automatic logic [CODE_W-1:0] sat_add(input logic [CODE_W-1:0] a,
                                                input logic [CODE_W-1:0] b);
    logic [CODE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CODE_W] ? {CODE_W{1'b1}} : s[CODE_W-1:0];
  endfunction

  function automatic logic [CODE_W-1:0] sat_sub(input logic [CODE_W-1:0] a,
                                                input logic [CODE_W-1:0] b);
    return (a < b) ? {CODE_W{1'b0}} : (a - b);
  endfunction

  logic up_s, dn_s;

  flag_sync u_sync_up (
    .clk   (IN_clk),
    .rst_b (RESET_b),
    .d     (flagU),
    .q     (up_s)
  );

  flag_sync u_sync_dn (
    .clk   (IN_clk),
    .rst_b (RESET_b),
    .d     (flagD),
    .q     (dn_s)
  );

  state_e            state_q,  state_d;
  logic [CODE_W-1:0] code_q,   code_d;
  logic [STEP_W-1:0] step_q,   step_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [REV_W-1:0]  rev_q,    rev_d;
  logic [RUN_W-1:0]  run_q,    run_d;
  dir_e              last_q,   last_d;
  logic              done_q,   done_d;
  logic              lock_q,   lock_d;

  dir_e              dir;
  logic [CODE_W-1:0] delta;
  logic [CODE_W-1:0] code_step;
  logic [REV_W-1:0]  rev_nxt;
  logic [RUN_W-1:0]  run_nxt;

  always_comb begin
    dir       = classify(up_s, dn_s);
    // Binary search moves by the current step; tracking moves by one LSB.
    delta     = (state_q == ST_SEARCH) ? CODE_W'(step_q) : CODE_W'(1);
    code_step = (dir == DIR_UP) ? sat_add(code_q, delta) : sat_sub(code_q, delta);
    rev_nxt   = (dir != last_q) ? (rev_q + REV_W'(1)) : '0;
    run_nxt   = (dir == last_q) ? (run_q + RUN_W'(1)) : RUN_W'(1);

    state_d  = state_q;
    code_d   = code_q;
    step_d   = step_q;
    settle_d = settle_q;
    rev_d    = rev_q;
    run_d    = run_q;
    last_d   = last_q;
    done_d   = done_q;
    lock_d   = lock_q;

    if (!EN) begin
      // Disable wins over any decision pending this cycle.
      state_d  = ST_IDLE;
      code_d   = CODE_MID;
      step_d   = STEP_INIT;
      settle_d = '0;
      rev_d    = '0;
      run_d    = '0;
      last_d   = DIR_NONE;
      done_d   = 1'b0;
      lock_d   = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d  = ST_SEARCH;
      code_d   = CODE_MID;
      step_d   = STEP_INIT;
      settle_d = SETTLE_LD;
    end else if (settle_q != '0) begin
      settle_d = settle_q - SET_W'(1);
    end else begin
      // Decision cycle: the new code becomes visible on the next cycle.
      settle_d = SETTLE_LD;
      if (dir != DIR_NONE) begin
        code_d = code_step;
        last_d = dir;
        case (state_q)
          ST_SEARCH: begin
            step_d = step_q >> 1;
            if (step_q == STEP_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_TRACK;
            end
          end
          ST_TRACK: begin
            rev_d = rev_nxt;
            if (rev_nxt == REV_W'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              lock_d  = 1'b1;
              // The locking decision opens the same-direction run.
              run_d   = RUN_W'(1);
            end
          end
          ST_LOCKED: begin
            run_d = run_nxt;
            if (run_nxt == RUN_W'(UNLOCK_CNT)) begin
              state_d = ST_TRACK;
              lock_d  = 1'b0;
              rev_d   = '0;
              run_d   = '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge IN_clk) begin
    if (!RESET_b) begin
      state_q  <= ST_IDLE;
      code_q   <= CODE_MID;
      step_q   <= STEP_INIT;
      settle_q <= '0;
      rev_q    <= '0;
      run_q    <= '0;
      last_q   <= DIR_NONE;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      rev_q    <= rev_d;
      run_q    <= run_d;
      last_q   <= last_d;
      done_q   <= done_d;
      lock_q   <= lock_d;
    end
  end

  assign DCO_code    = code_q;
  assign search_done = done_q;
  assign lock        = lock_q;

endmodule

// File: tb/tb_adpll_ctrl.sv
// tb_adpll_ctrl: directed scenarios plus randomized stimulus for adpll_ctrl,
// compared every cycle against a decision-level behavioural model.
module tb_adpll_ctrl;

  localparam int CODE_W     = 7;
  localparam int SETTLE     = 4;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 4;
  localparam int CODE_MAX   = (1 << CODE_W) - 1;
  localparam int CODE_MID   = 1 << (CODE_W - 1);
  localparam int STEP0      = 1 << (CODE_W - 2);

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_TRACK  = 2;
  localparam int M_LOCKED = 3;

  logic clk = 1'b0;
  logic rst_b;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  adpll_ctrl_if #(.CODE_W(CODE_W)) bus ();

  adpll_ctrl #(
    .CODE_W     (CODE_W),
    .SETTLE     (SETTLE),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .IN_clk      (clk),
    .RESET_b     (rst_b),
    .EN          (bus.en),
    .flagU       (bus.flag_u),
    .flagD       (bus.flag_d),
    .DCO_code    (bus.dco_code),
    .search_done (bus.search_done),
    .lock        (bus.lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural reference model, advanced once per rising edge.
  int m_mode = M_IDLE, m_code = CODE_MID, m_step = STEP0, m_wait = 0;
  int m_rev = 0, m_run = 0, m_last = 0, m_done = 0, m_lock = 0;
  int m_u1 = 0, m_u2 = 0, m_d1 = 0, m_d2 = 0;

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > CODE_MAX) return CODE_MAX;
    return v;
  endfunction

  task automatic model_clear();
    m_mode = M_IDLE; m_code = CODE_MID; m_step = STEP0; m_wait = 0;
    m_rev = 0; m_run = 0; m_last = 0; m_done = 0; m_lock = 0;
  endtask

  task automatic model_step(input logic rb, input logic en, input logic fu, input logic fd);
    int dir;
    if (!rb) begin
      model_clear();
      m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0;
      return;
    end
    dir = (m_u2 == 1 && m_d2 == 0) ? 1 : ((m_u2 == 0 && m_d2 == 1) ? -1 : 0);
    m_u2 = m_u1; m_u1 = int'(fu);
    m_d2 = m_d1; m_d1 = int'(fd);
    if (!en) begin
      model_clear();
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SEARCH;
      m_wait = SETTLE - 1;
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      m_wait = SETTLE - 1;
      if (dir != 0) begin
        if (m_mode == M_SEARCH) begin
          m_code = clamp(m_code + dir * m_step);
          if (m_step == 1) begin
            m_done = 1;
            m_mode = M_TRACK;
          end
          m_step = m_step / 2;
        end else if (m_mode == M_TRACK) begin
          m_code = clamp(m_code + dir);
          m_rev  = (dir != m_last) ? m_rev + 1 : 0;
          if (m_rev == LOCK_CNT) begin
            m_mode = M_LOCKED;
            m_lock = 1;
            m_run  = 1;
          end
        end else begin
          m_code = clamp(m_code + dir);
          m_run  = (dir == m_last) ? m_run + 1 : 1;
          if (m_run == UNLOCK_CNT) begin
            m_mode = M_TRACK;
            m_lock = 0;
            m_rev  = 0;
            m_run  = 0;
          end
        end
        m_last = dir;
      end
    end
  endtask

  always @(posedge clk) model_step(rst_b, bus.en, bus.flag_u, bus.flag_d);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_code", int'(bus.dco_code), m_code);
      chk("mdl_lock", int'(bus.lock), m_lock);
      chk("mdl_done", int'(bus.search_done), m_done);
    end
  end

  // Drive one decision and wait (bounded) until the code moves.
  task automatic decide(input logic u, input logic d, input string tag);
    int old;
    bit seen;
    bus.flag_u = u;
    bus.flag_d = d;
    old  = int'(bus.dco_code);
    seen = 1'b0;
    for (int i = 0; i < 10 * SETTLE && !seen; i++) begin
      @(negedge clk);
      if (int'(bus.dco_code) != old) seen = 1'b1;
    end
    chk({tag, "_moved"}, int'(seen), 1);
  endtask

  task automatic wait_code(input int target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (int'(bus.dco_code) == target) seen = 1'b1;
    end
    chk({tag, "_reached"}, int'(seen), 1);
  endtask

  int q[$];
  int exp_up[7]  = '{64, 96, 112, 120, 124, 126, 127};
  int exp_dn[8]  = '{64, 32, 16, 8, 4, 2, 1, 0};
  int st_u[6]    = '{1, 0, 1, 1, 0, 1};
  int st_code[6] = '{96, 80, 88, 92, 90, 91};

  task automatic capture(input int n);
    q.delete();
    q.push_back(int'(bus.dco_code));
    for (int i = 0; i < 300 && q.size() < n; i++) begin
      @(negedge clk);
      if (int'(bus.dco_code) != q[$]) q.push_back(int'(bus.dco_code));
    end
  endtask

  initial begin
    int hold;
    rst_b = 1'b0;
    bus.en = 1'b1;
    bus.flag_u = 1'b1;
    bus.flag_d = 1'b0;

    // Reset with EN high
    repeat (3) @(negedge clk);
    chk("rst_code", int'(bus.dco_code), 64);
    chk("rst_lock", int'(bus.lock), 0);
    chk("rst_done", int'(bus.search_done), 0);
    chk_en = 1'b1;
    rst_b = 1'b1;

    // Upward search with flagU held
    capture(7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("up_seq%0d", i), (i < q.size()) ? q[i] : -1, exp_up[i]);
    chk("up_done", int'(bus.search_done), 1);
    repeat (5 * SETTLE) begin
      @(negedge clk);
      chk("up_sat", int'(bus.dco_code), 127);
    end

    // Downward search with flagD held
    bus.en = 1'b0; bus.flag_u = 1'b0; bus.flag_d = 1'b1;
    @(negedge clk);
    chk("dis_code", int'(bus.dco_code), 64);
    chk("dis_done", int'(bus.search_done), 0);
    bus.en = 1'b1;
    capture(8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("dn_seq%0d", i), (i < q.size()) ? q[i] : -1, exp_dn[i]);
    chk("dn_done", int'(bus.search_done), 1);
    repeat (5 * SETTLE) begin
      @(negedge clk);
      chk("dn_sat", int'(bus.dco_code), 0);
    end

    // Enable drop mid-search at code 112
    bus.en = 1'b0; bus.flag_u = 1'b1; bus.flag_d = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    wait_code(112, "drop_pre");
    bus.en = 1'b0;
    @(negedge clk);
    chk("drop_code", int'(bus.dco_code), 64);
    chk("drop_lock", int'(bus.lock), 0);
    chk("drop_done", int'(bus.search_done), 0);
    bus.en = 1'b1;
    wait_code(96, "drop_restart");

    // Steer the search to 91, then alternate for lock
    bus.en = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      decide(st_u[i] == 1, st_u[i] == 0, $sformatf("steer%0d", i));
      chk($sformatf("steer%0d_code", i), int'(bus.dco_code), st_code[i]);
    end
    chk("steer_done", int'(bus.search_done), 1);
    for (int k = 1; k <= LOCK_CNT; k++) begin
      decide(k % 2 == 0, k % 2 == 1, $sformatf("rev%0d", k));
      chk($sformatf("rev%0d_code", k), int'(bus.dco_code), (k % 2 == 1) ? 90 : 91);
      chk($sformatf("rev%0d_lock", k), int'(bus.lock), (k == LOCK_CNT) ? 1 : 0);
    end

    // Unlock by a same-direction run, then ambiguous flags
    decide(1'b0, 1'b1, "ul_dn");
    chk("ul_dn_code", int'(bus.dco_code), 90);
    chk("ul_dn_lock", int'(bus.lock), 1);
    for (int k = 1; k <= UNLOCK_CNT; k++) begin
      decide(1'b1, 1'b0, $sformatf("ul_up%0d", k));
      chk($sformatf("ul_up%0d_code", k), int'(bus.dco_code), 90 + k);
      chk($sformatf("ul_up%0d_lock", k), int'(bus.lock), (k == UNLOCK_CNT) ? 0 : 1);
    end
    bus.flag_u = 1'b1; bus.flag_d = 1'b1;
    repeat (6 * SETTLE) @(negedge clk);
    chk("none_code", int'(bus.dco_code), 94);
    chk("none_lock", int'(bus.lock), 0);

    // Randomized traffic, checked by the per-cycle model comparison
    hold = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.flag_u = ~bus.flag_u;
          bus.flag_d = ~bus.flag_u;
          hold = SETTLE - 1;
        end else begin
          bus.flag_u = 1'($urandom_range(0, 1));
          bus.flag_d = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 12);
        end
      end else begin
        hold--;
      end
      bus.en = ($urandom_range(0, 249) != 0);
      rst_b  = ($urandom_range(0, 799) != 0);
    end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
